// File: rtl/hazard_scheduler.sv
// Decode-stage hazard scheduler: EX/MEM tag pipeline driving operand forwarding,
// load-use stalls and counted fetch squash. Define HAZARD_PERF_EN for stall/flush cycle counters.
module hazard_scheduler #(
    parameter int FLUSH_CYCLES      = 1,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_WIDTH         = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_reg_we,
    input  logic       id_is_load,
    input  logic       id_pc_src,
    output logic       stall,
    output logic       flush,
    output logic       issue,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt,
    output logic [CNT_WIDTH-1:0] perf_flush_cnt
`endif
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || LOAD_STALL_CYCLES < 1 ||
        LOAD_STALL_CYCLES > 3 || CNT_WIDTH < 1) begin : g_param_check
        $error("hazard_scheduler: parameter out of range");
    end

    logic       ex_v_r;
    logic       ex_we_r;
    logic       ex_ld_r;
    logic [4:0] ex_rd_r;
    logic       mem_v_r;
    logic       mem_we_r;
    logic [4:0] mem_rd_r;
    logic [1:0] stall_cnt_r;
    logic [2:0] flush_cnt_r;

    logic ex_live_s;
    logic mem_live_s;
    logic ex_hit_a_s;
    logic ex_hit_b_s;
    logic mem_hit_a_s;
    logic mem_hit_b_s;
    logic load_use_s;
    logic stall_s;
    logic flush_s;
    logic issue_s;

    function automatic logic operand_hit(input logic uses, input logic [4:0] src,
                                         input logic live, input logic [4:0] rd);
        return uses & live & (src == rd);
    endfunction

    // x0 is never a producer, so a slot writing x0 is treated as dead
    assign ex_live_s  = ex_v_r & ex_we_r & (ex_rd_r != 5'd0);
    assign mem_live_s = mem_v_r & mem_we_r & (mem_rd_r != 5'd0);

    assign ex_hit_a_s  = operand_hit(id_uses_rs1, id_rs1, ex_live_s, ex_rd_r);
    assign ex_hit_b_s  = operand_hit(id_uses_rs2, id_rs2, ex_live_s, ex_rd_r);
    assign mem_hit_a_s = operand_hit(id_uses_rs1, id_rs1, mem_live_s, mem_rd_r);
    assign mem_hit_b_s = operand_hit(id_uses_rs2, id_rs2, mem_live_s, mem_rd_r);

    // Squash dominates: an instruction being flushed never raises a load-use stall
    assign flush_s    = (flush_cnt_r != 3'd0);
    assign load_use_s = id_valid & ~flush_s & ex_ld_r & (ex_hit_a_s | ex_hit_b_s);
    assign stall_s    = ~flush_s & (load_use_s | (stall_cnt_r != 2'd0));
    assign issue_s    = id_valid & ~stall_s & ~flush_s;

    assign stall = stall_s;
    assign flush = flush_s;
    assign issue = issue_s;

    // rs1 forward select: youngest non-load producer in EX, else MEM
    always_comb begin
        fwd_a_sel = 2'b00;
        if (ex_hit_a_s && !ex_ld_r) begin
            fwd_a_sel = 2'b01;
        end else if (mem_hit_a_s) begin
            fwd_a_sel = 2'b10;
        end else begin
            fwd_a_sel = 2'b00;
        end
    end

    // rs2 forward select, same priority as rs1
    always_comb begin
        fwd_b_sel = 2'b00;
        if (ex_hit_b_s && !ex_ld_r) begin
            fwd_b_sel = 2'b01;
        end else if (mem_hit_b_s) begin
            fwd_b_sel = 2'b10;
        end else begin
            fwd_b_sel = 2'b00;
        end
    end

    // Tag pipeline: a non-issuing cycle shifts a bubble into EX
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_r   <= 1'b0;
            ex_we_r  <= 1'b0;
            ex_ld_r  <= 1'b0;
            ex_rd_r  <= 5'd0;
            mem_v_r  <= 1'b0;
            mem_we_r <= 1'b0;
            mem_rd_r <= 5'd0;
        end else begin
            mem_v_r  <= ex_v_r;
            mem_we_r <= ex_we_r;
            mem_rd_r <= ex_rd_r;
            ex_v_r   <= issue_s;
            ex_we_r  <= id_reg_we;
            ex_ld_r  <= id_is_load;
            ex_rd_r  <= id_rd;
        end
    end

    // Extra load-use bubbles beyond the detection cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 2'd0;
        end else if (stall_cnt_r != 2'd0) begin
            stall_cnt_r <= stall_cnt_r - 2'd1;
        end else if (load_use_s) begin
            stall_cnt_r <= 2'(LOAD_STALL_CYCLES - 1);
        end else begin
            stall_cnt_r <= 2'd0;
        end
    end

    // Fetch-squash countdown armed by an issuing taken control transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_r <= 3'd0;
        end else if (flush_cnt_r != 3'd0) begin
            flush_cnt_r <= flush_cnt_r - 3'd1;
        end else if (id_pc_src && issue_s) begin
            flush_cnt_r <= 3'(FLUSH_CYCLES);
        end else begin
            flush_cnt_r <= 3'd0;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating count of stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= {CNT_WIDTH{1'b0}};
        end else if (stall_s && (perf_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            perf_stall_cnt <= perf_stall_cnt + CNT_WIDTH'(1);
        end else begin
            perf_stall_cnt <= perf_stall_cnt;
        end
    end

    // Saturating count of flush cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_flush_cnt <= {CNT_WIDTH{1'b0}};
        end else if (flush_s && (perf_flush_cnt != {CNT_WIDTH{1'b1}})) begin
            perf_flush_cnt <= perf_flush_cnt + CNT_WIDTH'(1);
        end else begin
            perf_flush_cnt <= perf_flush_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: two instances (1-cycle and 3-cycle load stall) checked against
// an in-flight-history reference model, with directed test-plan sequences and random traffic.
module tb_hazard_scheduler;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ent_t;

    localparam int LSC0 = 1;
    localparam int FCY0 = 1;
    localparam int LSC1 = 3;
    localparam int FCY1 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd;
    logic       id_reg_we;
    logic       id_is_load;
    logic       id_pc_src;

    logic       d_stall [2];
    logic       d_flush [2];
    logic       d_issue [2];
    logic [1:0] d_fa [2];
    logic [1:0] d_fb [2];
`ifdef HAZARD_PERF_EN
    logic [31:0] d_ps [2];
    logic [31:0] d_pf [2];
`endif

    int checks = 0;
    int errors = 0;

    // reference model: last two issue decisions plus the cycle numbers at which stall/flush end
    ent_t hist [2][2];
    int   stall_end [2];
    int   flush_end [2];
    int   lsc [2];
    int   fcy [2];
    int   cyc;
    int   m_ps [2];
    int   m_pf [2];
    logic e_stall [2];
    logic e_flush [2];
    logic e_issue [2];
    logic e_lu [2];
    logic e_held [2];
    logic [1:0] e_fa [2];
    logic [1:0] e_fb [2];

    always #5 clk = ~clk;

    hazard_scheduler #(.FLUSH_CYCLES(FCY0), .LOAD_STALL_CYCLES(LSC0), .CNT_WIDTH(32)) u_dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_we(id_reg_we), .id_is_load(id_is_load), .id_pc_src(id_pc_src),
        .stall(d_stall[0]), .flush(d_flush[0]), .issue(d_issue[0]),
        .fwd_a_sel(d_fa[0]), .fwd_b_sel(d_fb[0])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(d_ps[0]), .perf_flush_cnt(d_pf[0])
`endif
    );

    hazard_scheduler #(.FLUSH_CYCLES(FCY1), .LOAD_STALL_CYCLES(LSC1), .CNT_WIDTH(32)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_we(id_reg_we), .id_is_load(id_is_load), .id_pc_src(id_pc_src),
        .stall(d_stall[1]), .flush(d_flush[1]), .issue(d_issue[1]),
        .fwd_a_sel(d_fa[1]), .fwd_b_sel(d_fb[1])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(d_ps[1]), .perf_flush_cnt(d_pf[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic live(input ent_t e);
        return e.v && e.we && (e.rd != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_of(input int k, input logic uses, input logic [4:0] src);
        if (uses && live(hist[k][0]) && !hist[k][0].ld && src == hist[k][0].rd) return 2'b01;
        if (uses && live(hist[k][1]) && src == hist[k][1].rd) return 2'b10;
        return 2'b00;
    endfunction

    task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld, input logic pc);
        id_valid = v;  id_rs1 = rs1;  id_rs2 = rs2;  id_uses_rs1 = u1;  id_uses_rs2 = u2;
        id_rd = rd;    id_reg_we = we; id_is_load = ld; id_pc_src = pc;
    endtask

    // evaluate the model and compare both instances, away from the active edge
    task automatic sample();
        logic hit;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e_flush[k] = (cyc < flush_end[k]);
            e_held[k]  = (cyc < stall_end[k]);
            hit = live(hist[k][0]) && hist[k][0].ld &&
                  ((id_uses_rs1 && id_rs1 == hist[k][0].rd) || (id_uses_rs2 && id_rs2 == hist[k][0].rd));
            e_lu[k]    = id_valid && !e_flush[k] && hit;
            e_stall[k] = !e_flush[k] && (e_lu[k] || e_held[k]);
            e_issue[k] = id_valid && !e_stall[k] && !e_flush[k];
            e_fa[k]    = fwd_of(k, id_uses_rs1, id_rs1);
            e_fb[k]    = fwd_of(k, id_uses_rs2, id_rs2);
            check_eq($sformatf("stall%0d", k), 32'(d_stall[k]), 32'(e_stall[k]));
            check_eq($sformatf("flush%0d", k), 32'(d_flush[k]), 32'(e_flush[k]));
            check_eq($sformatf("issue%0d", k), 32'(d_issue[k]), 32'(e_issue[k]));
            check_eq($sformatf("fwd_a%0d", k), 32'(d_fa[k]), 32'(e_fa[k]));
            check_eq($sformatf("fwd_b%0d", k), 32'(d_fb[k]), 32'(e_fb[k]));
`ifdef HAZARD_PERF_EN
            check_eq($sformatf("perf_stall%0d", k), d_ps[k], 32'(m_ps[k]));
            check_eq($sformatf("perf_flush%0d", k), d_pf[k], 32'(m_pf[k]));
`endif
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                hist[k][0] = '0;
                hist[k][1] = '0;
                stall_end[k] = 0;
                flush_end[k] = 0;
                m_ps[k] = 0;
                m_pf[k] = 0;
            end else begin
                if (e_stall[k]) m_ps[k]++;
                if (e_flush[k]) m_pf[k]++;
                if (e_lu[k] && !e_held[k]) stall_end[k] = cyc + lsc[k];
                if (id_pc_src && e_issue[k]) flush_end[k] = cyc + 1 + fcy[k];
                hist[k][1] = hist[k][0];
                hist[k][0] = {e_issue[k], id_rd, id_reg_we, id_is_load};
            end
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        lsc[0] = LSC0; lsc[1] = LSC1; fcy[0] = FCY0; fcy[1] = FCY1;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            hist[k][0] = '0; hist[k][1] = '0;
            stall_end[k] = 0; flush_end[k] = 0; m_ps[k] = 0; m_pf[k] = 0;
        end
        rst = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cyc = 1;

        // reset state
        sample();
        check_eq("rst_stall", 32'(d_stall[0]), 32'd0);
        check_eq("rst_flush", 32'(d_flush[0]), 32'd0);
        check_eq("rst_issue", 32'(d_issue[0]), 32'd0);
        check_eq("rst_fwd_a", 32'(d_fa[0]), 32'd0);
        check_eq("rst_fwd_b", 32'(d_fb[0]), 32'd0);
        advance();
        rst = 1'b0;

        // addi x5 ; add x6,x5,x5 -> EX forwarding on both operands
        set_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); step();
        set_in(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("ex_fwd_a", 32'(d_fa[0]), 32'd1);
        check_eq("ex_fwd_b", 32'(d_fb[0]), 32'd1);
        check_eq("ex_fwd_stall", 32'(d_stall[0]), 32'd0);
        check_eq("ex_fwd_issue", 32'(d_issue[0]), 32'd1);
        advance();

        // addi x5 ; nop ; add x7,x5,x0 -> MEM forwarding, x0 never forwards
        set_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); step();
        set_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        set_in(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("mem_fwd_a", 32'(d_fa[0]), 32'd2);
        check_eq("mem_fwd_b", 32'(d_fb[0]), 32'd0);
        advance();

        // lw x8 ; add x9,x8,x1 -> one bubble then MEM forward
        set_in(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0); step();
        set_in(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("lu_stall", 32'(d_stall[0]), 32'd1);
        check_eq("lu_issue", 32'(d_issue[0]), 32'd0);
        advance();
        sample();
        check_eq("lu_after_stall", 32'(d_stall[0]), 32'd0);
        check_eq("lu_after_fwd_a", 32'(d_fa[0]), 32'd2);
        check_eq("lu_after_issue", 32'(d_issue[0]), 32'd1);
        check_eq("lu3_still_stall", 32'(d_stall[1]), 32'd1);
        advance();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();

        // taken beq then a valid instruction during the squash
        set_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        sample();
        check_eq("br_issue", 32'(d_issue[0]), 32'd1);
        advance();
        set_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("br_flush", 32'(d_flush[0]), 32'd1);
        check_eq("br_squash_issue", 32'(d_issue[0]), 32'd0);
        check_eq("br_squash_stall", 32'(d_stall[0]), 32'd0);
        advance();
        sample();
        check_eq("br_flush_end", 32'(d_flush[0]), 32'd0);
        check_eq("br_resume_issue", 32'(d_issue[0]), 32'd1);
        advance();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();

        // x0 producers: no forward, no stall
        set_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        set_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("x0_fwd_a", 32'(d_fa[0]), 32'd0);
        check_eq("x0_fwd_b", 32'(d_fb[0]), 32'd0);
        advance();
        set_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); step();
        set_in(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        sample();
        check_eq("x0_load_stall", 32'(d_stall[0]), 32'd0);
        advance();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step();

        // reset during an active 3-cycle load stall
        set_in(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0); step();
        set_in(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); step();
        rst = 1'b1;
        sample();
        check_eq("lu3_pre_rst_stall", 32'(d_stall[1]), 32'd1);
        advance();
        rst = 1'b0;
        set_in(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        sample();
        check_eq("rst3_stall", 32'(d_stall[1]), 32'd0);
        check_eq("rst3_flush", 32'(d_flush[1]), 32'd0);
        check_eq("rst3_fwd_a", 32'(d_fa[1]), 32'd0);
        check_eq("rst3_fwd_b", 32'(d_fb[1]), 32'd0);
`ifdef HAZARD_PERF_EN
        check_eq("rst3_perf_stall", d_ps[1], 32'd0);
        check_eq("rst3_perf_flush", d_pf[1], 32'd0);
`endif
        advance();

        // random traffic on a small register window to provoke hazards
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_in(($urandom_range(0, 7) != 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
